// File: rtl/monitor_capture_ctrl_pkg.sv
// Shared types for the SPI Monitor capture front end: snapshot layout, presenter states, CTRL_IN bits.
package monitor_pkg;

    // Field order matches the Monitor wire order {signal, data, addr}
    typedef struct packed {
        logic [3:0]  signal;
        logic [15:0] data;
        logic [23:0] addr;
    } mon_snapshot_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED,
        ACTIVE
    } mon_pres_state_t;

    localparam int CTRL_CAPTURE_EN_BIT = 0;
    localparam int CTRL_STALL_BIT      = 1;

endpackage

// File: rtl/monitor_capture_ctrl_if.sv
// Bus-side and Monitor-side signal bundle of monitor_capture_ctrl; slave = the capture block.
interface monitor_capture_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              AS_N_IN;
    logic              UDS_N_IN;
    logic              LDS_N_IN;
    logic [23:0]       ADDR_IN;
    logic [15:0]       DATA_IN;
    logic [3:0]        OUTPUT_SIGNAL_IN;
    logic              SPISS_IN;
    logic [3:0]        CTRL_IN;
    logic [23:0]       MON_ADDR;
    logic [15:0]       MON_DATA;
    logic [3:0]        MON_SIGNAL;
    logic              DTACK_HOLD;
    logic              OVERFLOW;
    logic [LVL_W-1:0]  FIFO_LEVEL;

    modport slave (
        input  AS_N_IN, UDS_N_IN, LDS_N_IN, ADDR_IN, DATA_IN, OUTPUT_SIGNAL_IN,
        input  SPISS_IN, CTRL_IN,
        output MON_ADDR, MON_DATA, MON_SIGNAL, DTACK_HOLD, OVERFLOW, FIFO_LEVEL
    );

    modport master (
        output AS_N_IN, UDS_N_IN, LDS_N_IN, ADDR_IN, DATA_IN, OUTPUT_SIGNAL_IN,
        output SPISS_IN, CTRL_IN,
        input  MON_ADDR, MON_DATA, MON_SIGNAL, DTACK_HOLD, OVERFLOW, FIFO_LEVEL
    );

endinterface

// File: rtl/monitor_capture_ctrl_fifo.sv
// Snapshot FIFO (mon_snapshot_fifo): DEPTH entries, pointers one bit wider than the address.
module mon_snapshot_fifo
    import monitor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  mon_snapshot_t            wdata_i,
    output mon_snapshot_t            rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    mon_snapshot_t mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves on the same edge
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/monitor_capture_ctrl.sv
// 68000 bus-cycle capture sequencer feeding the SPI Monitor; one snapshot presented per SPI frame.
// Optional DTACK stall on a full FIFO is built when MONITOR_CAPTURE_STALL_EN is defined.
module monitor_capture_ctrl
    import monitor_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  MCLK_IN,
    input  logic                  RST_N_IN,
    monitor_capture_ctrl_if.slave bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    mon_snapshot_t             cap_q, head, mon_q;
    logic                      cap_vld_q;
    logic [SYNC_STAGES-1:0]    sync_q, fill_q;
    mon_pres_state_t           state_q;
    logic                      ovf_q;
    logic                      strobe, qual, push, pop, ss, ss_ok, full, empty;
    logic [LVL_W-1:0]          level;

    assign strobe = ~bus.AS_N_IN & ~(bus.UDS_N_IN & bus.LDS_N_IN);
    assign qual   = strobe & bus.CTRL_IN[CTRL_CAPTURE_EN_BIT];
    assign push   = bus.AS_N_IN & cap_vld_q;
    assign ss     = sync_q[SYNC_STAGES-1];
    // fill_q marks when the synchroniser holds real samples rather than its reset zeros
    assign ss_ok  = fill_q[SYNC_STAGES-1];
    assign pop    = (state_q == ACTIVE) & ~ss;

    always_ff @(posedge MCLK_IN) begin
        if (qual) cap_q <= '{signal: bus.OUTPUT_SIGNAL_IN, data: bus.DATA_IN, addr: bus.ADDR_IN};
    end

    always_ff @(posedge MCLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            cap_vld_q <= 1'b0;
            sync_q    <= '0;
            fill_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (qual)      cap_vld_q <= 1'b1;
            else if (push) cap_vld_q <= 1'b0;
            sync_q <= (sync_q << 1) | SYNC_STAGES'(bus.SPISS_IN);
            fill_q <= (fill_q << 1) | SYNC_STAGES'(1);
            if (!bus.CTRL_IN[CTRL_CAPTURE_EN_BIT]) ovf_q <= 1'b0;
            else if (push && full && !pop)         ovf_q <= 1'b1;
        end
    end

    mon_snapshot_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (MCLK_IN),
        .rst_n_i (RST_N_IN),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (cap_q),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    // Presenter: MON_* only change in LOAD, so they are frozen for the whole frame
    always_ff @(posedge MCLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state_q <= IDLE;
            mon_q   <= '0;
        end else begin
            case (state_q)
                IDLE:    if (!empty && ss_ok && !ss) state_q <= LOAD;
                LOAD: begin
                    mon_q   <= head;
                    state_q <= ARMED;
                end
                ARMED:   if (ss) state_q <= ACTIVE;
                ACTIVE:  if (!ss) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.MON_ADDR   = mon_q.addr;
    assign bus.MON_DATA   = mon_q.data;
    assign bus.MON_SIGNAL = mon_q.signal;
    assign bus.OVERFLOW   = ovf_q;
    assign bus.FIFO_LEVEL = level;

`ifdef MONITOR_CAPTURE_STALL_EN
    logic unused_ctrl;
    assign unused_ctrl    = ^bus.CTRL_IN[3:2];
    assign bus.DTACK_HOLD = strobe & bus.CTRL_IN[CTRL_STALL_BIT] & bus.CTRL_IN[CTRL_CAPTURE_EN_BIT]
                            & full & ~pop;
`else
    logic unused_ctrl;
    assign unused_ctrl    = ^bus.CTRL_IN[3:1];
    assign bus.DTACK_HOLD = 1'b0;
`endif

endmodule

// File: tb/tb_monitor_capture_ctrl.sv
// Directed bench for monitor_capture_ctrl; covers the stall path when MONITOR_CAPTURE_STALL_EN is defined.
`timescale 1ns/1ps
module tb_monitor_capture_ctrl;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    monitor_capture_ctrl_if #(.DEPTH(DEPTH)) bus ();

    monitor_capture_ctrl #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .MCLK_IN  (clk),
        .RST_N_IN (rst_n),
        .bus      (bus)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.AS_N_IN  = 1'b1;
        bus.UDS_N_IN = 1'b1;
        bus.LDS_N_IN = 1'b1;
    endtask

    task automatic bus_start(input logic [23:0] a, input logic [15:0] d, input logic [3:0] s);
        bus.ADDR_IN          = a;
        bus.DATA_IN          = d;
        bus.OUTPUT_SIGNAL_IN = s;
        bus.AS_N_IN          = 1'b0;
        bus.UDS_N_IN         = 1'b0;
        bus.LDS_N_IN         = 1'b1;
    endtask

    // Two qualified clocks, then AS high for the push edge; returns just after the push edge
    task automatic bus_cycle(input logic [23:0] a, input logic [15:0] d, input logic [3:0] s);
        bus_start(a, d, s);
        tick(2);
        bus_idle();
        tick(1);
    endtask

    task automatic frame();
        bus.SPISS_IN = 1'b1;
        tick(5);
        bus.SPISS_IN = 1'b0;
        tick(5);
    endtask

    task automatic test_reset();
        bus_idle();
        bus.ADDR_IN = '0; bus.DATA_IN = '0; bus.OUTPUT_SIGNAL_IN = '0;
        bus.SPISS_IN = 1'b0; bus.CTRL_IN = 4'h0;
        rst_n = 1'b0;
        tick(2);
        checks++; if ({bus.MON_SIGNAL, bus.MON_DATA, bus.MON_ADDR} !== 44'h0) begin errors++; $display("FAIL rst_mon got %h exp 0", {bus.MON_SIGNAL, bus.MON_DATA, bus.MON_ADDR}); end
        checks++; if (bus.FIFO_LEVEL !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", bus.FIFO_LEVEL); end
        checks++; if ({bus.OVERFLOW, bus.DTACK_HOLD} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {bus.OVERFLOW, bus.DTACK_HOLD}); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_write_capture();
        bus.CTRL_IN = 4'h1;
        bus_cycle(24'h123456, 16'hBEEF, 4'h5);
        checks++; if (bus.FIFO_LEVEL !== 3'd1) begin errors++; $display("FAIL t1_level got %0d exp 1", bus.FIFO_LEVEL); end
        tick(3);
        checks++; if (bus.MON_ADDR !== 24'h123456) begin errors++; $display("FAIL t1_addr got %h exp 123456", bus.MON_ADDR); end
        checks++; if (bus.MON_DATA !== 16'hBEEF) begin errors++; $display("FAIL t1_data got %h exp beef", bus.MON_DATA); end
        checks++; if (bus.MON_SIGNAL !== 4'h5) begin errors++; $display("FAIL t1_sig got %h exp 5", bus.MON_SIGNAL); end
        bus.SPISS_IN = 1'b1;
        tick(5);
        checks++; if (bus.MON_ADDR !== 24'h123456 || bus.FIFO_LEVEL !== 3'd1) begin errors++; $display("FAIL t1_midframe got %h/%0d exp 123456/1", bus.MON_ADDR, bus.FIFO_LEVEL); end
        bus.SPISS_IN = 1'b0;
        tick(5);
        checks++; if (bus.FIFO_LEVEL !== 3'd0) begin errors++; $display("FAIL t1_pop got %0d exp 0", bus.FIFO_LEVEL); end
    endtask

    task automatic test_read_capture();
        bus.ADDR_IN = 24'hABCDE0; bus.OUTPUT_SIGNAL_IN = 4'hA; bus.DATA_IN = 16'h0000;
        bus.AS_N_IN = 1'b0; bus.UDS_N_IN = 1'b0; bus.LDS_N_IN = 1'b0;
        tick(2);
        bus.DATA_IN = 16'hA5A5;
        tick(1);
        bus_idle();
        tick(3);
        checks++; if (bus.FIFO_LEVEL !== 3'd1) begin errors++; $display("FAIL t2_one_push got %0d exp 1", bus.FIFO_LEVEL); end
        checks++; if (bus.MON_DATA !== 16'hA5A5 || bus.MON_SIGNAL !== 4'hA) begin errors++; $display("FAIL t2_data got %h/%h exp a5a5/a", bus.MON_DATA, bus.MON_SIGNAL); end
        frame();
        checks++; if (bus.FIFO_LEVEL !== 3'd0) begin errors++; $display("FAIL t2_pop got %0d exp 0", bus.FIFO_LEVEL); end
        frame();
        checks++; if (bus.FIFO_LEVEL !== 3'd0 || bus.MON_DATA !== 16'hA5A5) begin errors++; $display("FAIL t2_empty_frame got %0d/%h exp 0/a5a5", bus.FIFO_LEVEL, bus.MON_DATA); end
    endtask

    task automatic test_overflow();
        bus.CTRL_IN = 4'h1;
        for (int i = 0; i < 5; i++) begin
            bus_cycle(24'h100000 + 24'(i), 16'h1000 + 16'(i), 4'(i));
            if (i == 3) begin
                checks++; if (bus.FIFO_LEVEL !== 3'd4 || bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL t3_fill got %0d/%b exp 4/0", bus.FIFO_LEVEL, bus.OVERFLOW); end
            end
        end
        checks++; if (bus.FIFO_LEVEL !== 3'd4 || bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL t3_drop got %0d/%b exp 4/1", bus.FIFO_LEVEL, bus.OVERFLOW); end
        bus.CTRL_IN = 4'h0;
        bus_cycle(24'h1FFFFF, 16'hFFFF, 4'hF);
        checks++; if (bus.OVERFLOW !== 1'b0 || bus.FIFO_LEVEL !== 3'd4) begin errors++; $display("FAIL t3_clear got %b/%0d exp 0/4", bus.OVERFLOW, bus.FIFO_LEVEL); end
        bus.CTRL_IN = 4'h1;
        tick(1);
    endtask

    task automatic test_push_pop_full();
        logic [23:0] exp_addr [4];
        exp_addr = '{24'h100001, 24'h100002, 24'h100003, 24'h200006};
        bus.SPISS_IN = 1'b1;
        tick(5);
        bus_start(24'h200006, 16'h6666, 4'h6);
        tick(1);
        bus.SPISS_IN = 1'b0;
        tick(2);
        bus_idle();
        tick(1);
        checks++; if (bus.FIFO_LEVEL !== 3'd4 || bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL t4_same_cycle got %0d/%b exp 4/0", bus.FIFO_LEVEL, bus.OVERFLOW); end
        tick(3);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.MON_ADDR !== exp_addr[i]) begin errors++; $display("FAIL t4_order%0d got %h exp %h", i, bus.MON_ADDR, exp_addr[i]); end
            frame();
        end
        checks++; if (bus.FIFO_LEVEL !== 3'd0) begin errors++; $display("FAIL t4_drain got %0d exp 0", bus.FIFO_LEVEL); end
    endtask

`ifdef MONITOR_CAPTURE_STALL_EN
    task automatic test_stall();
        logic [23:0] exp_addr [4];
        exp_addr = '{24'h300001, 24'h300002, 24'h300003, 24'h300004};
        bus.CTRL_IN = 4'h3;
        for (int i = 0; i < 4; i++) bus_cycle(24'h300000 + 24'(i), 16'h3000 + 16'(i), 4'h3);
        tick(2);
        bus_start(24'h300004, 16'h3004, 4'h3);
        #1;
        checks++; if (bus.DTACK_HOLD !== 1'b1) begin errors++; $display("FAIL t5_hold_start got %b exp 1", bus.DTACK_HOLD); end
        bus.SPISS_IN = 1'b1;
        tick(5);
        checks++; if (bus.DTACK_HOLD !== 1'b1 || bus.FIFO_LEVEL !== 3'd4) begin errors++; $display("FAIL t5_hold_frame got %b/%0d exp 1/4", bus.DTACK_HOLD, bus.FIFO_LEVEL); end
        bus.SPISS_IN = 1'b0;
        tick(2);
        checks++; if (bus.DTACK_HOLD !== 1'b0) begin errors++; $display("FAIL t5_release got %b exp 0", bus.DTACK_HOLD); end
        tick(1);
        bus_idle();
        tick(1);
        checks++; if (bus.FIFO_LEVEL !== 3'd4 || bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL t5_captured got %0d/%b exp 4/0", bus.FIFO_LEVEL, bus.OVERFLOW); end
        tick(2);
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.MON_ADDR !== exp_addr[i]) begin errors++; $display("FAIL t5_order%0d got %h exp %h", i, bus.MON_ADDR, exp_addr[i]); end
            frame();
        end
        bus.CTRL_IN = 4'h1;
    endtask
`else
    task automatic test_stall();
        bus.CTRL_IN = 4'h3;
        for (int i = 0; i < 4; i++) bus_cycle(24'h300000 + 24'(i), 16'h3000 + 16'(i), 4'h3);
        bus_start(24'h300004, 16'h3004, 4'h3);
        #1;
        checks++; if (bus.DTACK_HOLD !== 1'b0) begin errors++; $display("FAIL t5_no_hold got %b exp 0", bus.DTACK_HOLD); end
        tick(2);
        bus_idle();
        tick(1);
        checks++; if (bus.FIFO_LEVEL !== 3'd4 || bus.OVERFLOW !== 1'b1) begin errors++; $display("FAIL t5_drop got %0d/%b exp 4/1", bus.FIFO_LEVEL, bus.OVERFLOW); end
        bus.CTRL_IN = 4'h0;
        tick(1);
        bus.CTRL_IN = 4'h1;
    endtask
`endif

    task automatic test_reset_mid_frame();
        bus.CTRL_IN = 4'h1;
        bus_cycle(24'h400000, 16'h4444, 4'h4);
        tick(3);
        bus.SPISS_IN = 1'b1;
        tick(5);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.MON_SIGNAL, bus.MON_DATA, bus.MON_ADDR} !== 44'h0 || bus.FIFO_LEVEL !== 3'd0 || bus.OVERFLOW !== 1'b0) begin errors++; $display("FAIL t6_reset got %h/%0d/%b exp 0/0/0", {bus.MON_SIGNAL, bus.MON_DATA, bus.MON_ADDR}, bus.FIFO_LEVEL, bus.OVERFLOW); end
        tick(2);
        rst_n = 1'b1;
        bus_cycle(24'h500000, 16'h5555, 4'h5);
        tick(4);
        checks++; if (bus.MON_ADDR !== 24'h0 || bus.FIFO_LEVEL !== 3'd1) begin errors++; $display("FAIL t6_partial got %h/%0d exp 0/1", bus.MON_ADDR, bus.FIFO_LEVEL); end
        bus.SPISS_IN = 1'b0;
        tick(5);
        checks++; if (bus.MON_ADDR !== 24'h500000 || bus.FIFO_LEVEL !== 3'd1) begin errors++; $display("FAIL t6_armed got %h/%0d exp 500000/1", bus.MON_ADDR, bus.FIFO_LEVEL); end
        frame();
        checks++; if (bus.FIFO_LEVEL !== 3'd0) begin errors++; $display("FAIL t6_pop got %0d exp 0", bus.FIFO_LEVEL); end
    endtask

    initial begin
        test_reset();
        test_write_capture();
        test_read_capture();
        test_overflow();
        test_push_pop_full();
        test_stall();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
